// File: rtl/m_time_keeper_pkg.sv
// Shared types and limits for the time-of-day core: mode encodings, BCD digit pairs
// and the increment-with-wrap helper used for every hour/minute/second pair.
package m_time_keeper_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_pair_t;

  localparam bcd_pair_t SEC_MAX  = '{tens: 4'd5, ones: 4'd9};
  localparam bcd_pair_t MIN_MAX  = '{tens: 4'd5, ones: 4'd9};
  localparam bcd_pair_t HOUR_MAX = '{tens: 4'd2, ones: 4'd3};

  // Increment a BCD pair; ones roll 9->0 into tens, and the pair wraps to 00 at lim.
  function automatic bcd_pair_t bcd_inc(input bcd_pair_t v, input bcd_pair_t lim);
    bcd_pair_t r;
    r = v;
    if (v == lim) begin
      r = '0;
    end else if (v.ones == 4'd9) begin
      r.tens = v.tens + 4'd1;
      r.ones = '0;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/m_press_detect.sv
// Two-flop synchronizer plus rising-edge detect for one debounced switch level.
// All flops reset high so a switch held through reset never yields a press.
module m_press_detect (
  input  logic clk,
  input  logic res,
  input  logic lvl_in,
  output logic press_out
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= lvl_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press_out = sync2 & ~prev;

endmodule

// File: rtl/m_time_keeper.sv
// Time-of-day core: 24 h BCD clock with a RUN/SET_HOUR/SET_MIN mode FSM driven by
// mode/increment switch presses, plus a free-running one-second prescaler.
module m_time_keeper
  import m_time_keeper_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       sw_mode,
  input  logic       sw_inc,
  output logic [3:0] h10,
  output logic [3:0] h1,
  output logic [3:0] m10,
  output logic [3:0] m1,
  output logic [3:0] s10,
  output logic [3:0] s1,
  output logic [1:0] mode,
  output logic       sec_pulse
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescale;
  logic          tick;
  logic          mode_press;
  logic          inc_press;
  mode_e         state;
  bcd_pair_t     hrs, mins, secs;
  bcd_pair_t     hrs_nx, mins_nx, secs_nx;
  logic          sec_wrap, min_wrap;
  logic          pulse;

  m_press_detect u_mode_press (
    .clk       (clk),
    .res       (res),
    .lvl_in    (sw_mode),
    .press_out (mode_press)
  );

  m_press_detect u_inc_press (
    .clk       (clk),
    .res       (res),
    .lvl_in    (sw_inc),
    .press_out (inc_press)
  );

  assign tick     = (prescale == PS_LAST);
  assign secs_nx  = bcd_inc(secs, SEC_MAX);
  assign mins_nx  = bcd_inc(mins, MIN_MAX);
  assign hrs_nx   = bcd_inc(hrs, HOUR_MAX);
  assign sec_wrap = (secs == SEC_MAX);
  assign min_wrap = (mins == MIN_MAX);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= MODE_RUN;
      hrs      <= '0;
      mins     <= '0;
      secs     <= '0;
      prescale <= '0;
      pulse    <= 1'b0;
    end else begin
      prescale <= tick ? '0 : prescale + PW'(1);
      pulse    <= 1'b0;
      case (state)
        MODE_SET_HOUR: begin
          if (mode_press) begin
            state <= MODE_SET_MIN;
          end else if (inc_press) begin
            hrs <= hrs_nx;
          end
        end
        MODE_SET_MIN: begin
          // Restart the second so the first tick lands a full period after leaving.
          if (mode_press) begin
            state    <= MODE_RUN;
            secs     <= '0;
            prescale <= '0;
          end else if (inc_press) begin
            mins <= mins_nx;
          end
        end
        default: begin
          // RUN, and the unused encoding 3 which behaves as RUN.
          if (tick) begin
            secs  <= secs_nx;
            pulse <= 1'b1;
            if (sec_wrap) begin
              mins <= mins_nx;
              if (min_wrap) begin
                hrs <= hrs_nx;
              end
            end
          end
          if (mode_press) begin
            state <= MODE_SET_HOUR;
          end
        end
      endcase
    end
  end

  assign h10       = hrs.tens;
  assign h1        = hrs.ones;
  assign m10       = mins.tens;
  assign m1        = mins.ones;
  assign s10       = secs.tens;
  assign s1        = secs.ones;
  assign mode      = state;
  assign sec_pulse = pulse;

endmodule

// File: tb/tb_m_time_keeper.sv
// Scoreboard bench for m_time_keeper with TICK_DIV=4: stimulus queues expected
// snapshots and per-pulse times; a negedge monitor pops and compares them.
module tb_m_time_keeper;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       sw_mode = 1'b0;
  logic       sw_inc = 1'b0;
  logic [3:0] h10, h1, m10, m1, s10, s1;
  logic [1:0] mode;
  logic       sec_pulse;

  m_time_keeper #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .res       (res),
    .sw_mode   (sw_mode),
    .sw_inc    (sw_inc),
    .h10       (h10),
    .h1        (h1),
    .m10       (m10),
    .m1        (m1),
    .s10       (s10),
    .s1        (s1),
    .mode      (mode),
    .sec_pulse (sec_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    kind;   // 0: state snapshot, 1: pulse tally
    int    h, m, s, md, pl;
    int    cnt;
  } chk_t;

  typedef struct {
    int h, m, s;
    int cyc;
  } pexp_t;

  chk_t  chk_q[$];
  pexp_t pulse_q[$];
  int    compared = 0;
  int    mismatched = 0;
  int    pulses_seen = 0;
  int    pulse_idx = 0;
  int    cyc = 0;
  bit    track = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] pack_time(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Monitor: checks every pulse while tracking, and any queued snapshot/tally.
  always @(negedge clk) begin
    logic [23:0] act;
    logic [23:0] ex;
    pexp_t p;
    chk_t  c;
    act = {h10, h1, m10, m1, s10, s1};
    if (track && sec_pulse) begin
      pulses_seen++;
      pulse_idx++;
      compared++;
      if (pulse_q.size() == 0) begin
        mismatched++;
        $display("FAIL pulse_unexpected: sec_pulse=1 time %h cycle %0d, required no pulse", act, cyc);
      end else begin
        p  = pulse_q.pop_front();
        ex = pack_time(p.h, p.m, p.s);
        if (act !== ex || cyc != p.cyc) begin
          mismatched++;
          $display("FAIL pulse_%0d: got time %h at cycle %0d, required %h at cycle %0d",
                   pulse_idx, act, cyc, ex, p.cyc);
        end
      end
    end
    if (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      compared++;
      if (c.kind == 0) begin
        ex = pack_time(c.h, c.m, c.s);
        if (act !== ex || mode !== 2'(c.md) || sec_pulse !== 1'(c.pl)) begin
          mismatched++;
          $display("FAIL %s: got time %h mode %0d pulse %0d, required time %h mode %0d pulse %0d",
                   c.name, act, mode, sec_pulse, ex, c.md, c.pl);
        end
      end else begin
        if (pulse_q.size() != 0 || pulses_seen != c.cnt) begin
          mismatched++;
          $display("FAIL %s: got pending %0d seen %0d, required pending 0 seen %0d",
                   c.name, pulse_q.size(), pulses_seen, c.cnt);
        end
      end
    end
  end

  task automatic snap(input string nm, input int h, input int m, input int s,
                      input int md, input int pl);
    chk_t c;
    c.name = nm; c.kind = 0; c.h = h; c.m = m; c.s = s; c.md = md; c.pl = pl; c.cnt = 0;
    chk_q.push_back(c);
    @(negedge clk); #1;
  endtask

  task automatic tally(input string nm, input int cnt);
    chk_t c;
    c.name = nm; c.kind = 1; c.h = 0; c.m = 0; c.s = 0; c.md = 0; c.pl = 0; c.cnt = cnt;
    chk_q.push_back(c);
    @(negedge clk); #1;
  endtask

  task automatic push_pulse(input int t, input int at_cyc);
    pexp_t p;
    p.h = (t / 3600) % 24; p.m = (t / 60) % 60; p.s = t % 60; p.cyc = at_cyc;
    pulse_q.push_back(p);
  endtask

  // Idle gap, then hold the switch(es) until the 3rd edge (the update edge); returns #1 after it.
  task automatic press(input bit pm, input bit pi, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    sw_mode = pm; sw_inc = pi;
    repeat (3) @(posedge clk);
    #1;
    sw_mode = 1'b0; sw_inc = 1'b0;
  endtask

  task automatic incs(input int n);
    repeat (n) press(1'b0, 1'b1, 4);
  endtask

  task automatic do_reset();
    sw_mode = 1'b0; sw_inc = 1'b0;
    res = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, x, base;
    // Both switches held high through reset and the whole first minute.
    sw_mode = 1'b1; sw_inc = 1'b1;
    #1 res = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    snap("reset_state", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    res = 1'b1;
    r = cyc;
    base = pulses_seen;
    for (int k = 1; k <= 60; k++) push_pulse(k, r + 4 * k);
    track = 1'b1;
    repeat (241) @(posedge clk);
    #1;
    snap("run_one_minute", 0, 1, 0, 0, 0);
    tally("pulses_one_minute", base + 60);
    track = 1'b0;

    // Set hour by three presses, seconds frozen, then back to RUN.
    do_reset();
    press(1'b1, 1'b0, 4);
    snap("enter_set_hour", 0, 0, 1, 1, 0);
    base = pulses_seen;
    track = 1'b1;
    incs(3);
    snap("set_hour_plus3", 3, 0, 1, 1, 0);
    press(1'b1, 1'b0, 4);
    snap("enter_set_min", 3, 0, 1, 2, 0);
    press(1'b1, 1'b0, 4);
    x = cyc;
    push_pulse(3 * 3600 + 1, x + 4);
    snap("exit_to_run", 3, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    tally("first_tick_after_exit", base + 1);
    track = 1'b0;

    // Wrap boundaries in the SET modes, then roll over midnight.
    do_reset();
    press(1'b1, 1'b0, 4);
    base = pulses_seen;
    track = 1'b1;
    incs(23);
    snap("set_hour_23", 23, 0, 1, 1, 0);
    incs(1);
    snap("hour_wrap", 0, 0, 1, 1, 0);
    incs(23);
    press(1'b1, 1'b0, 4);
    snap("set_min_entry", 23, 0, 1, 2, 0);
    incs(59);
    snap("set_min_59", 23, 59, 1, 2, 0);
    incs(1);
    snap("min_wrap_no_carry", 23, 0, 1, 2, 0);
    incs(59);
    press(1'b1, 1'b0, 4);
    x = cyc;
    for (int k = 1; k <= 60; k++) push_pulse(23 * 3600 + 59 * 60 + k, x + 4 * k);
    snap("exit_at_2359", 23, 59, 0, 0, 0);
    repeat (240) @(posedge clk);
    #1;
    snap("midnight_rollover", 0, 0, 0, 0, 1);
    tally("pulses_to_midnight", base + 60);
    track = 1'b0;

    // Increment ignored in RUN.
    do_reset();
    press(1'b0, 1'b1, 4);
    snap("run_ignores_inc", 0, 0, 1, 0, 0);

    // Simultaneous mode and inc presses: mode wins.
    do_reset();
    press(1'b1, 1'b1, 4);
    snap("mode_beats_inc", 0, 0, 1, 1, 0);

    // Mode press landing on the tick edge: tick applied and mode advances.
    do_reset();
    press(1'b1, 1'b0, 5);
    snap("tick_with_mode", 0, 0, 2, 1, 1);

    // Asynchronous reset in the middle of SET_HOUR.
    do_reset();
    press(1'b1, 1'b0, 4);
    incs(5);
    snap("set_hour_5", 5, 0, 1, 1, 0);
    @(posedge clk); #1;
    res = 1'b0;
    snap("async_reset_mid_set", 0, 0, 0, 0, 0);
    res = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
